// File: rtl/linear_scheduler.sv
// Round-robin scheduler sharing one linear core among NUM_REQ requesters.
// One job in flight: grant in IDLE, issue in SEND, collect in WAIT, return in RESP.
module linear_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int PRECISION    = 8,
    parameter int NUM_FEATURES = 1,
    parameter int N            = 8,
    parameter int M            = 8
) (
    input  logic                                                      clk,
    input  logic                                                      rst,
    input  logic                                                      ce,
    input  logic [NUM_REQ-1:0]                                        req_valid,
    output logic [NUM_REQ-1:0]                                        req_ready,
    input  logic [NUM_REQ-1:0][NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] req_features,
    output logic                                                      core_valid,
    input  logic                                                      core_ready,
    output logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0]             core_features,
    input  logic                                                      core_out_valid,
    output logic                                                      core_out_ready,
    input  logic [NUM_FEATURES-1:0][M-1:0][PRECISION-1:0]             core_out,
    output logic [NUM_REQ-1:0]                                        resp_valid,
    input  logic [NUM_REQ-1:0]                                        resp_ready,
    output logic [NUM_FEATURES-1:0][M-1:0][PRECISION-1:0]             resp_out,
    output logic                                                      busy,
    output logic [31:0]                                               job_count
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;

    state_t           state, state_next;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_id;
    logic [PTR_W-1:0] grant;
    logic             grant_found;
    int               scan_idx;
    logic             req_hs, core_hs, out_hs, resp_hs;

    // Descending scan so the requester closest to rr_ptr is the last (winning) write.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        scan_idx    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[scan_idx]) begin
                grant       = PTR_W'(scan_idx);
                grant_found = 1'b1;
            end
        end
    end

    // NOTE: rst gates the grant combinationally so req_ready is low for the whole reset pulse.
    assign req_hs  = (state == IDLE) && ce && !rst && grant_found;
    assign core_hs = (state == SEND) && ce && core_ready;
    assign out_hs  = (state == WAIT) && ce && core_out_valid;
    assign resp_hs = (state == RESP) && ce && resp_ready[grant_id];

    assign req_ready      = req_hs ? (NUM_REQ'(1) << grant) : '0;
    assign core_valid     = (state == SEND);
    assign core_out_ready = (state == WAIT);
    assign resp_valid     = (state == RESP) ? (NUM_REQ'(1) << grant_id) : '0;
    assign busy           = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_hs)  state_next = SEND;
            SEND:    if (core_hs) state_next = WAIT;
            WAIT:    if (out_hs)  state_next = RESP;
            RESP:    if (resp_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            job_count <= '0;
        end else if (ce) begin
            state <= state_next;
            if (req_hs)
                grant_id <= grant;
            if (resp_hs) begin
                rr_ptr    <= (grant_id == PTR_W'(NUM_REQ - 1)) ? '0 : grant_id + PTR_W'(1);
                job_count <= job_count + 32'd1;
            end
        end
    end

    // Operand and result registers also clear on reset so no stale job data is visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_features <= '0;
            resp_out      <= '0;
        end else if (ce) begin
            if (req_hs)
                core_features <= req_features[grant];
            if (out_hs)
                resp_out <= core_out;
        end
    end

endmodule

// File: tb/tb_linear_scheduler.sv
// Directed bench for linear_scheduler: reset, single job, fairness, backpressure,
// clock enable, reset mid-job and withdrawal, with hand-computed expectations.
module tb_linear_scheduler;

    localparam int NR = 4;
    localparam int P  = 8;
    localparam int NF = 1;
    localparam int NN = 8;
    localparam int MM = 8;

    logic clk = 1'b0;
    logic rst, ce;
    logic [NR-1:0]                     req_valid, req_ready;
    logic [NR-1:0][NF-1:0][NN-1:0][P-1:0] req_features;
    logic                              core_valid, core_ready;
    logic [NF-1:0][NN-1:0][P-1:0]      core_features;
    logic                              core_out_valid, core_out_ready;
    logic [NF-1:0][MM-1:0][P-1:0]      core_out;
    logic [NR-1:0]                     resp_valid, resp_ready;
    logic [NF-1:0][MM-1:0][P-1:0]      resp_out;
    logic                              busy;
    logic [31:0]                       job_count;

    int n_checks = 0;
    int n_pass   = 0;

    linear_scheduler #(
        .NUM_REQ(NR), .PRECISION(P), .NUM_FEATURES(NF), .N(NN), .M(MM)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .req_valid(req_valid), .req_ready(req_ready), .req_features(req_features),
        .core_valid(core_valid), .core_ready(core_ready), .core_features(core_features),
        .core_out_valid(core_out_valid), .core_out_ready(core_out_ready), .core_out(core_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_out(resp_out),
        .busy(busy), .job_count(job_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] feat(input int i);
        return 64'h0102_0304_0506_0708 + 64'(i) * 64'h1111_1111_1111_1111;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Serves one job for requester g with the core answering at once; next_valid
    // replaces req_valid just before the response handshake.
    task automatic job(input int g, input logic [63:0] res, input logic [NR-1:0] next_valid);
        #1;
        check($sformatf("job%0d_req_ready", g), 64'(req_ready), 64'(NR'(1) << g));
        tick;
        #1;
        check($sformatf("job%0d_core_valid", g), 64'(core_valid), 64'd1);
        check($sformatf("job%0d_core_features", g), 64'(core_features), feat(g));
        core_ready = 1'b1;
        tick;
        core_ready     = 1'b0;
        core_out_valid = 1'b1;
        core_out       = res;
        tick;
        core_out_valid = 1'b0;
        #1;
        check($sformatf("job%0d_resp_valid", g), 64'(resp_valid), 64'(NR'(1) << g));
        check($sformatf("job%0d_resp_out", g), 64'(resp_out), res);
        resp_ready = '1;
        req_valid  = next_valid;
        tick;
        resp_ready = '0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NR; i++) req_features[i] = feat(i);
        rst = 1'b1; ce = 1'b1; req_valid = '1;
        core_ready = 1'b0; core_out_valid = 1'b0; core_out = '0; resp_ready = '0;
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_job_count", 64'(job_count), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_core_valid", 64'(core_valid), 64'd0);
        check("rst_core_out_ready", 64'(core_out_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_core_features", 64'(core_features), 64'd0);
        check("rst_resp_out", 64'(resp_out), 64'd0);
        req_valid = '0;
        tick;
        rst = 1'b0;

        // Single job with the core answering two cycles after issue.
        req_valid = 4'b0001;
        #1;
        check("t1_req_ready", 64'(req_ready), 64'd1);
        tick;
        req_valid = '0;
        #1;
        check("t1_core_valid", 64'(core_valid), 64'd1);
        check("t1_core_features", 64'(core_features), feat(0));
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_no_req_ready", 64'(req_ready), 64'd0);
        core_ready = 1'b1;
        tick;
        core_ready = 1'b0;
        #1;
        check("t1_core_valid_drop", 64'(core_valid), 64'd0);
        check("t1_core_out_ready", 64'(core_out_ready), 64'd1);
        tick;
        core_out_valid = 1'b1;
        core_out       = 64'hDEAD_BEEF_0123_4567;
        #1;
        check("t1_no_early_resp", 64'(resp_valid), 64'd0);
        tick;
        core_out_valid = 1'b0;
        #1;
        check("t1_resp_valid", 64'(resp_valid), 64'd1);
        check("t1_resp_out", 64'(resp_out), 64'hDEAD_BEEF_0123_4567);
        resp_ready = 4'b0001;
        tick;
        resp_ready = '0;
        #1;
        check("t1_job_count", 64'(job_count), 64'd1);
        check("t1_idle", 64'(busy), 64'd0);
        check("t1_resp_drop", 64'(resp_valid), 64'd0);

        // Fairness: all requesters valid for eight jobs, starting from rr_ptr 0.
        do_reset;
        req_valid = '1;
        for (int j = 0; j < 8; j++)
            job(j % NR, 64'hC0DE_0000_0000_0000 | 64'(j), (j == 7) ? 4'b0000 : 4'b1111);
        #1;
        check("fair_job_count", 64'(job_count), 64'd8);

        // Backpressure on the core and on the response; rr_ptr is 0 here.
        req_valid = 4'b0010;
        #1;
        check("bp_req_ready", 64'(req_ready), 64'b0010);
        tick;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp_core_valid_hold%0d", k), 64'(core_valid), 64'd1);
            check($sformatf("bp_send_no_ready%0d", k), 64'(req_ready), 64'd0);
            tick;
        end
        core_ready = 1'b1;
        tick;
        core_ready     = 1'b0;
        core_out_valid = 1'b1;
        core_out       = 64'h1234_5678_9ABC_DEF0;
        tick;
        core_out = 64'hFFFF_0000_FFFF_0000;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_resp_valid_hold%0d", k), 64'(resp_valid), 64'b0010);
            check($sformatf("bp_resp_out_hold%0d", k), 64'(resp_out), 64'h1234_5678_9ABC_DEF0);
            check($sformatf("bp_resp_no_ready%0d", k), 64'(req_ready), 64'd0);
            tick;
        end
        core_out_valid = 1'b0;
        resp_ready     = 4'b0010;
        req_valid      = '0;
        tick;
        resp_ready = '0;
        #1;
        check("bp_job_count", 64'(job_count), 64'd9);
        check("bp_resp_drop", 64'(resp_valid), 64'd0);

        // Clock enable low during WAIT and RESP; rr_ptr is 2 here.
        req_valid = 4'b0100;
        #1;
        check("ce_req_ready", 64'(req_ready), 64'b0100);
        ce = 1'b0;
        #1;
        check("ce_low_no_req_ready", 64'(req_ready), 64'd0);
        ce = 1'b1;
        tick;
        req_valid  = '0;
        core_ready = 1'b1;
        tick;
        core_ready     = 1'b0;
        ce             = 1'b0;
        core_out_valid = 1'b1;
        core_out       = 64'hCAFE_F00D_5555_AAAA;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("ce_wait_hold%0d", k), 64'(core_out_ready), 64'd1);
            check($sformatf("ce_no_capture%0d", k), 64'(resp_valid), 64'd0);
            tick;
        end
        ce = 1'b1;
        tick;
        core_out_valid = 1'b0;
        #1;
        check("ce_capture_valid", 64'(resp_valid), 64'b0100);
        check("ce_capture_data", 64'(resp_out), 64'hCAFE_F00D_5555_AAAA);
        ce         = 1'b0;
        resp_ready = 4'b0100;
        tick;
        #1;
        check("ce_no_resp_hs", 64'(job_count), 64'd9);
        check("ce_resp_hold", 64'(resp_valid), 64'b0100);
        ce = 1'b1;
        tick;
        resp_ready = '0;
        #1;
        check("ce_job_count", 64'(job_count), 64'd10);
        check("ce_idle", 64'(busy), 64'd0);

        // Reset while waiting for the core; rr_ptr is 3 here.
        req_valid = 4'b1000;
        #1;
        check("rw_req_ready", 64'(req_ready), 64'b1000);
        tick;
        req_valid  = '0;
        core_ready = 1'b1;
        tick;
        core_ready = 1'b0;
        #1;
        check("rw_in_wait", 64'(core_out_ready), 64'd1);
        rst = 1'b1;
        #1;
        check("rw_busy_async", 64'(busy), 64'd0);
        check("rw_job_count", 64'(job_count), 64'd0);
        check("rw_core_out_ready", 64'(core_out_ready), 64'd0);
        rst            = 1'b0;
        core_out_valid = 1'b1;
        core_out       = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int k = 0; k < 3; k++) begin
            tick;
            #1;
            check($sformatf("rw_stale_resp%0d", k), 64'(resp_valid), 64'd0);
            check($sformatf("rw_stale_busy%0d", k), 64'(busy), 64'd0);
        end
        core_out_valid = 1'b0;

        // Withdrawal: req 2 valid while 1 is served, then dropped; rr_ptr becomes 2.
        req_valid = 4'b0110;
        job(1, 64'h0000_0000_0000_1111, 4'b1000);
        job(3, 64'h0000_0000_0000_3333, 4'b0011);
        job(0, 64'h0000_0000_0000_0000, 4'b0000);
        #1;
        check("wd_job_count", 64'(job_count), 64'd3);
        check("wd_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
